// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the MEM-stage data port and the data memory.
// Stores queue in a circular FIFO, coalesce on address hits, and forward to loads.
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            addr_MEM,
  input  logic [DATA_W-1:0]            wdata_MEM,
  input  logic                         memwrite_MEM,
  output logic [DATA_W-1:0]            rdata_MEM,
  output logic                         sb_full,
  output logic                         sb_empty,
  output logic [$clog2(DEPTH+1)-1:0]   sb_count,
  output logic                         sb_overflow,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ready,
  output logic [ADDR_W-1:0]            mem_raddr,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic              w_hit;
  logic [PTR_W-1:0]  w_hit_idx;
  logic              w_drain;
  logic              w_hit_draining;
  logic              w_coalesce;
  logic              w_room;
  logic              w_enq;
  logic              w_drop;

  // One address match serves both load forwarding and store coalescing; at
  // most one valid entry holds any address, so the match is never ambiguous.
  // NOTE: every signal gets a default before the loop, otherwise a latch is inferred.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == addr_MEM)) begin
        w_hit     = 1'b1;
        w_hit_idx = PTR_W'(i);
      end
    end
  end

  assign w_drain        = mem_we && mem_ready;
  assign w_hit_draining = w_hit && (w_hit_idx == r_head) && w_drain;
  assign w_coalesce     = memwrite_MEM && w_hit && !w_hit_draining;
  assign w_room         = (r_count < CNT_W'(DEPTH)) || w_drain;
  assign w_enq          = memwrite_MEM && !w_coalesce && w_room;
  assign w_drop         = memwrite_MEM && !w_coalesce && !w_room;

  // Control state. When full and draining, head == tail: the enqueue is
  // written after the drain so the slot ends up valid again.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_drain);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // NOTE: the address/data arrays carry no reset; the valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= addr_MEM;
      r_data[r_tail] <= wdata_MEM;
    end else if (w_coalesce) begin
      r_data[w_hit_idx] <= wdata_MEM;
    end
  end

  assign sb_count    = r_count;
  assign sb_empty    = (r_count == '0);
  assign sb_full     = (r_count == CNT_W'(DEPTH));
  assign sb_overflow = r_overflow;

  // Head outputs read as zero when empty, so reset clears them at once.
  assign mem_we    = !sb_empty;
  assign mem_addr  = mem_we ? r_addr[r_head] : '0;
  assign mem_wdata = mem_we ? r_data[r_head] : '0;

  assign mem_raddr = addr_MEM;
  assign rdata_MEM = w_hit ? r_data[w_hit_idx] : mem_rdata;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: memory writes are logged at the falling
// edge and compared against hand-computed address/data sequences.
module tb_dmem_store_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] addr_MEM;
  logic [31:0] wdata_MEM;
  logic        memwrite_MEM;
  logic [31:0] rdata_MEM;
  logic        sb_full;
  logic        sb_empty;
  logic [2:0]  sb_count;
  logic        sb_overflow;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  dmem_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .addr_MEM(addr_MEM), .wdata_MEM(wdata_MEM), .memwrite_MEM(memwrite_MEM),
    .rdata_MEM(rdata_MEM),
    .sb_full(sb_full), .sb_empty(sb_empty), .sb_count(sb_count), .sb_overflow(sb_overflow),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory read model: a recognisable pattern keyed on the read address.
  assign mem_rdata = {16'hC0DE, mem_raddr[15:0]};

  // Inputs are stable by the falling edge, so a request seen here is accepted at the next rising edge.
  always @(negedge clk) begin
    if (rst && mem_we && mem_ready) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0; memwrite_MEM = 1'b0; mem_ready = 1'b0;
    addr_MEM = '0; wdata_MEM = '0;
    step(); step();
    rst = 1'b1;
    step();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic rdy);
    addr_MEM = a; wdata_MEM = d; memwrite_MEM = 1'b1; mem_ready = rdy;
    step();
    memwrite_MEM = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic load_check(input string nm, input logic [31:0] a, input logic [31:0] exp);
    addr_MEM = a;
    #1;
    n_cmp++;
    if (rdata_MEM !== exp) begin
      n_err++; $display("FAIL %s addr=%h got=%h exp=%h", nm, a, rdata_MEM, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (sb_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got=%b exp=1", sb_empty); end
    n_cmp++; if (sb_full !== 1'b0) begin n_err++; $display("FAIL rst_full got=%b exp=0", sb_full); end
    n_cmp++; if (sb_count !== 3'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", sb_count); end
    n_cmp++; if (sb_overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got=%b exp=0", sb_overflow); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we got=%b exp=0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_err++; $display("FAIL rst_head got=%h/%h exp=0/0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_single_store();
    do_reset();
    // The store being presented must not forward to a same-cycle load.
    addr_MEM = 32'h10; wdata_MEM = 32'hAAAA; memwrite_MEM = 1'b1; mem_ready = 1'b0;
    #1;
    n_cmp++; if (rdata_MEM !== 32'hC0DE0010) begin n_err++; $display("FAIL t1_noself got=%h exp=c0de0010", rdata_MEM); end
    step();
    memwrite_MEM = 1'b0;
    n_cmp++; if (sb_count !== 3'd1) begin n_err++; $display("FAIL t1_count got=%0d exp=1", sb_count); end
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL t1_we got=%b exp=1", mem_we); end
    n_cmp++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hAAAA) begin
      n_err++; $display("FAIL t1_head got=%h/%h exp=10/aaaa", mem_addr, mem_wdata);
    end
    load_check("t1_fwd", 32'h10, 32'hAAAA);
    load_check("t1_miss", 32'h14, 32'hC0DE0014);
    n_cmp++; if (mem_raddr !== 32'h14) begin n_err++; $display("FAIL t1_raddr got=%h exp=14", mem_raddr); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) store(32'h10 + i, 32'h100 + i, 1'b0);
    n_cmp++; if (sb_full !== 1'b1) begin n_err++; $display("FAIL t2_full got=%b exp=1", sb_full); end
    store(32'h20, 32'h2020, 1'b0);
    n_cmp++; if (sb_overflow !== 1'b1) begin n_err++; $display("FAIL t2_ovf got=%b exp=1", sb_overflow); end
    n_cmp++; if (sb_count !== 3'd4) begin n_err++; $display("FAIL t2_count got=%0d exp=4", sb_count); end
    n_cmp++; if (mem_addr !== 32'h10) begin n_err++; $display("FAIL t2_head got=%h exp=10", mem_addr); end
    load_check("t2_dropped", 32'h20, 32'hC0DE0020);
    load_check("t2_fwd3", 32'h13, 32'h103);
  endtask

  task automatic test_drain_enqueue_full();
    logic [31:0] ea [5] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h20};
    logic [31:0] ed [5] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h2020};
    do_reset();
    for (int i = 0; i < 4; i++) store(32'h10 + i, 32'h100 + i, 1'b0);
    store(32'h20, 32'h2020, 1'b1);
    n_cmp++; if (sb_count !== 3'd4) begin n_err++; $display("FAIL t3_count got=%0d exp=4", sb_count); end
    n_cmp++; if (sb_overflow !== 1'b0) begin n_err++; $display("FAIL t3_ovf got=%b exp=0", sb_overflow); end
    n_cmp++; if (mem_addr !== 32'h11) begin n_err++; $display("FAIL t3_head got=%h exp=11", mem_addr); end
    load_check("t3_fwd_new", 32'h20, 32'h2020);
    load_check("t3_drained", 32'h10, 32'hC0DE0010);
    mem_ready = 1'b1;
    repeat (4) step();
    mem_ready = 1'b0;
    n_cmp++; if (sb_empty !== 1'b1) begin n_err++; $display("FAIL t3_empty got=%b exp=1", sb_empty); end
    n_cmp++;
    if (wr_addr_q.size() != 5) begin
      n_err++; $display("FAIL t3_nwrites got=%0d exp=5", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
          n_err++; $display("FAIL t3_write%0d got=%h/%h exp=%h/%h", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_coalesce();
    do_reset();
    store(32'h10, 32'h1, 1'b0);
    store(32'h10, 32'h2, 1'b0);
    n_cmp++; if (sb_count !== 3'd1) begin n_err++; $display("FAIL t4_count got=%0d exp=1", sb_count); end
    load_check("t4_fwd", 32'h10, 32'h2);
    // Coalesce into a non-head entry while the head drains.
    store(32'h11, 32'h5, 1'b0);
    store(32'h11, 32'h6, 1'b1);
    n_cmp++; if (sb_count !== 3'd1) begin n_err++; $display("FAIL t4_count2 got=%0d exp=1", sb_count); end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    n_cmp++;
    if (wr_addr_q.size() != 2) begin
      n_err++; $display("FAIL t4_nwrites got=%0d exp=2", wr_addr_q.size());
    end else if (wr_addr_q[0] !== 32'h10 || wr_data_q[0] !== 32'h2 ||
                 wr_addr_q[1] !== 32'h11 || wr_data_q[1] !== 32'h6) begin
      n_err++; $display("FAIL t4_writes got=%h/%h,%h/%h exp=10/2,11/6",
                        wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
    end
  endtask

  task automatic test_head_drain_hit();
    do_reset();
    store(32'h10, 32'h1, 1'b0);
    addr_MEM = 32'h10; wdata_MEM = 32'h2; memwrite_MEM = 1'b1; mem_ready = 1'b1;
    #1;
    n_cmp++; if (rdata_MEM !== 32'h1) begin n_err++; $display("FAIL t5_drainfwd got=%h exp=1", rdata_MEM); end
    step();
    memwrite_MEM = 1'b0; mem_ready = 1'b0;
    n_cmp++; if (sb_count !== 3'd1) begin n_err++; $display("FAIL t5_count got=%0d exp=1", sb_count); end
    n_cmp++; if (mem_addr !== 32'h10 || mem_wdata !== 32'h2) begin
      n_err++; $display("FAIL t5_head got=%h/%h exp=10/2", mem_addr, mem_wdata);
    end
    load_check("t5_fwd", 32'h10, 32'h2);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    n_cmp++; if (sb_count !== 3'd0) begin n_err++; $display("FAIL t5_count_end got=%0d exp=0", sb_count); end
    n_cmp++;
    if (wr_addr_q.size() != 2) begin
      n_err++; $display("FAIL t5_nwrites got=%0d exp=2", wr_addr_q.size());
    end else if (wr_data_q[0] !== 32'h1 || wr_data_q[1] !== 32'h2 ||
                 wr_addr_q[0] !== 32'h10 || wr_addr_q[1] !== 32'h10) begin
      n_err++; $display("FAIL t5_order got=%h,%h exp=1,2", wr_data_q[0], wr_data_q[1]);
    end
  endtask

  task automatic test_reset_midcycle();
    do_reset();
    for (int i = 0; i < 3; i++) store(32'h30 + i, 32'h300 + i, 1'b0);
    n_cmp++; if (sb_count !== 3'd3) begin n_err++; $display("FAIL t6_count_pre got=%0d exp=3", sb_count); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL t6_we_async got=%b exp=0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL t6_addr_async got=%h exp=0", mem_addr); end
    step();
    rst = 1'b1;
    step();
    n_cmp++; if (sb_count !== 3'd0) begin n_err++; $display("FAIL t6_count got=%0d exp=0", sb_count); end
    load_check("t6_load", 32'h31, 32'hC0DE0031);
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr_MEM = 32'h40 + i; wdata_MEM = 32'h4000 + i; memwrite_MEM = 1'b1;
      step();
    end
    memwrite_MEM = 1'b0;
    n_cmp++; if (sb_count !== 3'd1) begin n_err++; $display("FAIL b2b_count got=%0d exp=1", sb_count); end
    step();
    mem_ready = 1'b0;
    n_cmp++; if (sb_empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty got=%b exp=1", sb_empty); end
    n_cmp++;
    if (wr_addr_q.size() != 8) begin
      n_err++; $display("FAIL b2b_nwrites got=%0d exp=8", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (wr_addr_q[i] !== 32'h40 + i || wr_data_q[i] !== 32'h4000 + i) begin
          n_err++; $display("FAIL b2b_write%0d got=%h/%h exp=%h/%h", i, wr_addr_q[i], wr_data_q[i],
                            32'h40 + i, 32'h4000 + i);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; addr_MEM = '0; wdata_MEM = '0; memwrite_MEM = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_single_store();
    test_full_overflow();
    test_drain_enqueue_full();
    test_coalesce();
    test_head_drain_hit();
    test_reset_midcycle();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
